cache_fill_bridge: RTL and testbench

Burst-fill bridge that sits directly downstream of the two-way instruction/data cache and upstream of the SDRAM controller port. It accepts the cache's line-fill request, issues one aligned 4-word read to the memory controller, collects the returned words (which may arrive with arbitrary gaps), then replays them to the cache as one fill strobe plus four words on consecutive cycles. This matches the cache's gap-free fill sequence. A timeout guarantees the cache never hangs on a lost burst.

---
 rtl/cache_fill_bridge.sv | 190 +++++++++++++++++++
 tb/tb_cache_fill_bridge.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : cache_fill_bridge
//  Purpose  : Burst-fill bridge between the I/D cache and the SDRAM controller.
//             Accepts a cache line-fill read, issues one aligned 4-word read,
//             collects the returned words (arbitrary gaps allowed), then
//             replays them to the cache as a fill pulse plus four words on
//             consecutive cycles. A timer abandons a burst that never finishes.
//  Ports    :
//    clk          in   system clock, rising edge
//    reset        in   synchronous active-low reset
//    cache_req    in   line-fill request (level)
//    cache_addr   in   request byte address, bits 2:0 ignored
//    cache_rw     in   1 = read; writes are ignored
//    cache_fill   out  one-cycle pulse marking word 0 on cache_data
//    cache_data   out  registered fill word
//    mem_req      out  read request to SDRAM controller
//    mem_addr     out  8-byte aligned burst address
//    mem_ack      in   controller accepted the request (pulse)
//    mem_dvalid   in   one strobe per returned word
//    mem_data     in   returned word
//    busy         out  high whenever not idle
//    err_timeout  out  sticky timeout flag, cleared only by reset
//  Revision : 1.0  initial release
// ============================================================================
module cache_fill_bridge #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cache_req,
  input  logic [31:0] cache_addr,
  input  logic        cache_rw,
  output logic        cache_fill,
  output logic [15:0] cache_data,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic        mem_dvalid,
  input  logic [15:0] mem_data,
  output logic        busy,
  output logic        err_timeout
);

  localparam logic [15:0] c_TIMER_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_COLLECT = 3'd2,
    S_REPLAY0 = 3'd3,
    S_REPLAY1 = 3'd4,
    S_REPLAY2 = 3'd5,
    S_REPLAY3 = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [15:0] timer_q, timer_d;
  logic        fill_q, fill_d;
  logic [15:0] data_q, data_d;
  logic        err_q, err_d;
  logic [15:0] word_q [4];
  logic [15:0] word_d [4];

  logic        w_capture;

  // Byte-offset bits are deliberately discarded; the burst is always aligned.
  logic        unused_addr_lsbs;
  assign unused_addr_lsbs = ^cache_addr[2:0];

  // A word is accepted in the ack cycle of ISSUE or anywhere in COLLECT;
  // strobes in any other state (stray, 5th word, late data) are dropped.
  assign w_capture = mem_dvalid &&
                     (((state_q == S_ISSUE) && mem_ack) || (state_q == S_COLLECT));

  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    cnt_d      = cnt_q;
    timer_d    = timer_q;
    fill_d     = 1'b0;
    data_d     = data_q;
    err_d      = err_q;
    word_d     = word_q;

    case (state_q)
      S_IDLE: begin
        if (cache_req && cache_rw) begin
          mem_addr_d = {cache_addr[31:3], 3'b000};
          mem_req_d  = 1'b1;
          cnt_d      = 2'd0;
          timer_d    = 16'd0;
          state_d    = S_ISSUE;
        end
      end

      S_ISSUE, S_COLLECT: begin
        timer_d = timer_q + 16'd1;
        if (w_capture) begin
          word_d[cnt_q] = mem_data;
          cnt_d         = cnt_q + 2'd1;
        end
        if ((state_q == S_ISSUE) && mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = S_COLLECT;
        end
        // A 4th word landing on the timeout cycle still counts as a clean fill.
        if (w_capture && (cnt_q == 2'd3)) begin
          state_d = S_REPLAY0;
        end else if (timer_q == c_TIMER_LAST) begin
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          // Zero every slot not filled by now (a word captured this cycle survives).
          for (int i = 0; i < 4; i++) begin
            if ((2'(i) > cnt_q) || ((2'(i) == cnt_q) && !w_capture)) begin
              word_d[i] = 16'h0000;
            end
          end
          state_d = S_REPLAY0;
        end
      end

      S_REPLAY0: begin
        data_d  = word_q[0];
        fill_d  = 1'b1;
        state_d = S_REPLAY1;
      end

      S_REPLAY1: begin
        data_d  = word_q[1];
        state_d = S_REPLAY2;
      end

      S_REPLAY2: begin
        data_d  = word_q[2];
        state_d = S_REPLAY3;
      end

      S_REPLAY3: begin
        data_d  = word_q[3];
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= 32'd0;
      cnt_q      <= 2'd0;
      timer_q    <= 16'd0;
      fill_q     <= 1'b0;
      data_q     <= 16'h0000;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      cnt_q      <= cnt_d;
      timer_q    <= timer_d;
      fill_q     <= fill_d;
      data_q     <= data_d;
      err_q      <= err_d;
    end
  end

  // Line buffer needs no reset: it is always fully written before replay.
  always_ff @(posedge clk) begin
    word_q <= word_d;
  end

  assign cache_fill  = fill_q;
  assign cache_data  = data_q;
  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign busy        = (state_q != S_IDLE);
  assign err_timeout = err_q;

endmodule
`default_nettype wire

// File: tb/tb_cache_fill_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_cache_fill_bridge
//  Purpose  : Directed self-checking bench for cache_fill_bridge. Two
//             instances share one stimulus set: dut_a uses the default
//             TIMEOUT, dut_b uses TIMEOUT=16; sel routes stimulus/outputs.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cache_fill_bridge;

  localparam int TO_B = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic        cache_req, cache_rw, mem_ack, mem_dvalid;
  logic [31:0] cache_addr;
  logic [15:0] mem_data;

  logic        a_req, a_ack, a_dv, b_req, b_ack, b_dv;
  logic        a_fill, b_fill, a_mreq, b_mreq, a_busy, b_busy, a_err, b_err;
  logic [15:0] a_data, b_data;
  logic [31:0] a_maddr, b_maddr;

  logic        cache_fill, mem_req, busy;
  logic [15:0] cache_data;
  logic [31:0] mem_addr;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;

  assign a_req = cache_req  & ~sel;
  assign a_ack = mem_ack    & ~sel;
  assign a_dv  = mem_dvalid & ~sel;
  assign b_req = cache_req  & sel;
  assign b_ack = mem_ack    & sel;
  assign b_dv  = mem_dvalid & sel;

  assign cache_fill = sel ? b_fill  : a_fill;
  assign cache_data = sel ? b_data  : a_data;
  assign mem_req    = sel ? b_mreq  : a_mreq;
  assign mem_addr   = sel ? b_maddr : a_maddr;
  assign busy       = sel ? b_busy  : a_busy;

  cache_fill_bridge dut_a (
    .clk(clk), .reset(reset), .cache_req(a_req), .cache_addr(cache_addr),
    .cache_rw(cache_rw), .cache_fill(a_fill), .cache_data(a_data),
    .mem_req(a_mreq), .mem_addr(a_maddr), .mem_ack(a_ack),
    .mem_dvalid(a_dv), .mem_data(mem_data), .busy(a_busy), .err_timeout(a_err)
  );

  cache_fill_bridge #(.TIMEOUT(TO_B)) dut_b (
    .clk(clk), .reset(reset), .cache_req(b_req), .cache_addr(cache_addr),
    .cache_rw(cache_rw), .cache_fill(b_fill), .cache_data(b_data),
    .mem_req(b_mreq), .mem_addr(b_maddr), .mem_ack(b_ack),
    .mem_dvalid(b_dv), .mem_data(mem_data), .busy(b_busy), .err_timeout(b_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // One full request: accept, ack after ack_dly cycles, deliver nw words with
  // gaps g0..g3 (g0=0 puts word 0 in the ack cycle), then check the replay.
  task automatic burst(input logic [31:0] addr, input int ack_dly,
                       input int g0, input int g1, input int g2, input int g3,
                       input int nw,
                       input logic [15:0] w0, input logic [15:0] w1,
                       input logic [15:0] w2, input logic [15:0] w3,
                       input bit extra);
    int e0, ed, n, k0, exp_fill;
    int g[4];
    logic [15:0] w[4];
    logic [15:0] ew;
    g = '{g0, g1, g2, g3};
    w = '{w0, w1, w2, w3};

    cache_req = 1'b1; cache_rw = 1'b1; cache_addr = addr;
    tick();
    e0 = cyc;
    check_eq("mreq_set", 32'(mem_req), 32'd1);
    check_eq("maddr", mem_addr, {addr[31:3], 3'b000});
    check_eq("busy_hi", 32'(busy), 32'd1);
    repeat (ack_dly - 1) tick();

    mem_ack = 1'b1;
    k0 = 0;
    if (g[0] == 0 && nw > 0) begin
      mem_dvalid = 1'b1; mem_data = w[0]; k0 = 1;
    end
    tick();
    mem_ack = 1'b0; mem_dvalid = 1'b0;
    ed = cyc;
    check_eq("mreq_clr", 32'(mem_req), 32'd0);

    for (int k = k0; k < nw; k++) begin
      repeat ((k == 0) ? g[0] - 1 : g[k]) begin
        tick();
        check_eq("no_early_fill", 32'(cache_fill), 32'd0);
      end
      mem_dvalid = 1'b1; mem_data = w[k];
      tick();
      mem_dvalid = 1'b0;
      ed = cyc;
    end

    if (extra) begin
      mem_dvalid = 1'b1; mem_data = 16'hDEAD;
    end
    n = 0;
    while (!cache_fill && n < 64) begin
      tick();
      mem_dvalid = 1'b0;
      n++;
    end
    mem_dvalid = 1'b0;
    exp_fill = (nw == 4) ? ed + 1 : e0 + TO_B + 1;
    check_eq("fill_cycle", 32'(cyc), 32'(exp_fill));
    cache_req = 1'b0;
    check_eq("fill_pulse", 32'(cache_fill), 32'd1);
    ew = (nw > 0) ? w[0] : 16'h0000;
    check_eq("word0", 32'(cache_data), 32'(ew));
    for (int k = 1; k < 4; k++) begin
      tick();
      ew = (k < nw) ? w[k] : 16'h0000;
      check_eq("fill_low", 32'(cache_fill), 32'd0);
      check_eq("wordn", 32'(cache_data), 32'(ew));
    end
    check_eq("busy_lo", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    sel = 1'b0; reset = 1'b0;
    cache_req = 1'b0; cache_rw = 1'b0; cache_addr = 32'd0;
    mem_ack = 1'b0; mem_dvalid = 1'b0; mem_data = 16'h0000;
    tick(); tick();
    check_eq("rst_fill", 32'(cache_fill), 32'd0);
    check_eq("rst_data", 32'(cache_data), 32'd0);
    check_eq("rst_mreq", 32'(mem_req), 32'd0);
    check_eq("rst_maddr", mem_addr, 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_err_b", 32'(b_err), 32'd0);
    reset = 1'b1;
    tick();

    // Basic fill
    burst(32'h0012_345E, 3, 0, 0, 0, 0, 4, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 1'b0);

    // Gapped return, plus a 5th strobe during replay
    burst(32'h0012_345E, 3, 0, 5, 1, 7, 4, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 1'b1);
    check_eq("last_hold", 32'(cache_data), 32'h4444);

    // Write request and stray strobes in IDLE
    cache_req = 1'b1; cache_rw = 1'b0; cache_addr = 32'h0000_ABC0; mem_data = 16'h7777;
    for (int i = 0; i < 4; i++) begin
      mem_dvalid = i[0];
      mem_ack    = ~i[0];
      tick();
      check_eq("wr_mreq", 32'(mem_req), 32'd0);
      check_eq("wr_busy", 32'(busy), 32'd0);
      check_eq("wr_fill", 32'(cache_fill), 32'd0);
    end
    cache_req = 1'b0; mem_dvalid = 1'b0; mem_ack = 1'b0;
    check_eq("wr_data_hold", 32'(cache_data), 32'h4444);
    tick();

    // Back-to-back requests (second raised right after word 3)
    burst(32'h1000_0003, 1, 0, 0, 0, 0, 4, 16'hA001, 16'hA002, 16'hA003, 16'hA004, 1'b0);
    burst(32'h2000_0019, 2, 1, 0, 2, 0, 4, 16'hB001, 16'hB002, 16'hB003, 16'hB004, 1'b0);

    // Timeout on the TIMEOUT=16 instance
    sel = 1'b1;
    tick();
    check_eq("to_err_pre", 32'(b_err), 32'd0);
    burst(32'h0000_0040, 3, 0, 0, 0, 0, 2, 16'hAAAA, 16'hBBBB, 16'h0000, 16'h0000, 1'b0);
    check_eq("to_err_set", 32'(b_err), 32'd1);
    burst(32'h0000_0080, 1, 0, 0, 0, 0, 4, 16'hC001, 16'hC002, 16'hC003, 16'hC004, 1'b0);
    check_eq("to_err_sticky", 32'(b_err), 32'd1);

    // Reset in the middle of a collect
    sel = 1'b0;
    tick();
    cache_req = 1'b1; cache_rw = 1'b1; cache_addr = 32'h0000_1007;
    tick();
    mem_ack = 1'b1; mem_dvalid = 1'b1; mem_data = 16'h5555;
    tick();
    mem_ack = 1'b0; mem_data = 16'h6666;
    tick();
    mem_dvalid = 1'b0; cache_req = 1'b0;
    check_eq("mid_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    tick();
    check_eq("mr_fill", 32'(cache_fill), 32'd0);
    check_eq("mr_data", 32'(cache_data), 32'd0);
    check_eq("mr_mreq", 32'(mem_req), 32'd0);
    check_eq("mr_maddr", mem_addr, 32'd0);
    check_eq("mr_busy", 32'(busy), 32'd0);
    check_eq("mr_err_b", 32'(b_err), 32'd0);
    reset = 1'b1;
    burst(32'h0000_2000, 2, 0, 3, 0, 1, 4, 16'hD001, 16'hD002, 16'hD003, 16'hD004, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
